// File: rtl/rsa_ctrl_pkg.sv
// Shared definitions for the RSA command controller: state encoding and
// default sizing of the run-cycle counter and timeout.
package rsa_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_ABORT  = 2'd3
  } ctrl_state_t;

  localparam int          DEF_CNT_W   = 16;
  localparam int unsigned DEF_TIMEOUT = 32'h0000_FFFF;

endpackage

// File: rtl/rsa_cycle_counter.sv
// Run-cycle counter with synchronous clear and count enable. It does not
// saturate; the controller stops incrementing before the timeout limit, so
// the count can never wrap.
module rsa_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count register: clear wins over increment, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (!rstb) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rsa_cmd_ctrl.sv
// Command controller for the RSA engine. Merges GPIO and SPI start/stop
// pulses, launches the engine, tracks how long it runs and ends every run
// with exactly one of done / abort / timeout recorded in sticky flags.
module rsa_cmd_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             gpio_start_cmd,
  input  logic             gpio_stop_cmd,
  input  logic             spi_start_cmd,
  input  logic             spi_stop_cmd,
  input  logic             eng_done,
  output logic             eng_start,
  output logic             eng_abort,
  output logic             busy,
  output logic             done_flag,
  output logic             abort_flag,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] run_cycles
);

  // Last count value allowed in RUN; reaching it forces an abort.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  ctrl_state_t state;

  logic start;
  logic stop;
  logic at_limit;
  logic launch_go;
  logic run_inc;

  assign start    = gpio_start_cmd | spi_start_cmd;
  assign stop     = gpio_stop_cmd  | spi_stop_cmd;
  assign at_limit = (run_cycles == LAST_CNT);

  // A new run clears the counter on the same edge that enters LAUNCH; the
  // counter advances only on RUN cycles that do not exit RUN, so the final
  // value equals the index of the exit cycle and tops out at TIMEOUT-1.
  assign launch_go = ena && (state == ST_IDLE) && start && !stop;
  assign run_inc   = ena && (state == ST_RUN) && !eng_done && !stop && !at_limit;

  rsa_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (launch_go),
    .en    (run_inc),
    .count (run_cycles)
  );

  // Control FSM with registered pulse, busy and sticky flag outputs.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      // NOTE: reset drops straight to IDLE without an abort pulse; the engine
      // shares this reset and needs no separate abort.
      state        <= ST_IDLE;
      eng_start    <= 1'b0;
      eng_abort    <= 1'b0;
      busy         <= 1'b0;
      done_flag    <= 1'b0;
      abort_flag   <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (!ena) begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state        <= ST_LAUNCH;
            eng_start    <= 1'b1;
            busy         <= 1'b1;
            done_flag    <= 1'b0;
            abort_flag   <= 1'b0;
            timeout_flag <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (eng_done) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done_flag <= 1'b1;
          end else if (stop) begin
            state      <= ST_ABORT;
            eng_abort  <= 1'b1;
            abort_flag <= 1'b1;
          end else if (at_limit) begin
            state        <= ST_ABORT;
            eng_abort    <= 1'b1;
            timeout_flag <= 1'b1;
          end
        end
        ST_ABORT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// Self-checking bench for rsa_cmd_ctrl: a cycle-by-cycle vector table for
// the basic transitions plus directed sequences for the multi-cycle cases.
// A second instance with TIMEOUT=8 covers the timeout path.
module tb_rsa_cmd_ctrl;

  logic clk = 1'b0;
  logic rstb, ena, gs, gp, ss, sp, done;

  logic        es, ea, busy, df, af, tf;
  logic [15:0] rc;
  logic        to_es, to_ea, to_busy, to_df, to_af, to_tf;
  logic [15:0] to_rc;

  int n_tests = 0;
  int n_fail  = 0;
  int es_cnt  = 0;
  int ea_cnt  = 0;
  int to_ea_cnt = 0;

  always #5 clk = ~clk;

  rsa_cmd_ctrl dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .gpio_start_cmd(gs), .gpio_stop_cmd(gp),
    .spi_start_cmd(ss), .spi_stop_cmd(sp), .eng_done(done),
    .eng_start(es), .eng_abort(ea), .busy(busy),
    .done_flag(df), .abort_flag(af), .timeout_flag(tf), .run_cycles(rc)
  );

  rsa_cmd_ctrl #(.CNT_W(16), .TIMEOUT(8)) dut_to (
    .clk(clk), .rstb(rstb), .ena(ena),
    .gpio_start_cmd(gs), .gpio_stop_cmd(gp),
    .spi_start_cmd(ss), .spi_stop_cmd(sp), .eng_done(done),
    .eng_start(to_es), .eng_abort(to_ea), .busy(to_busy),
    .done_flag(to_df), .abort_flag(to_af), .timeout_flag(to_tf), .run_cycles(to_rc)
  );

  typedef struct packed {
    logic        rstb, ena, gs, gp, ss, sp, done;
    logic [5:0]  flags;   // es ea busy df af tf
    logic [15:0] rc;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and sample #1 after the edge, tallying output pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (es)    es_cnt++;
    if (ea)    ea_cnt++;
    if (to_ea) to_ea_cnt++;
  endtask

  function automatic logic [21:0] outs();
    return {es, ea, busy, df, af, tf, rc};
  endfunction

  task automatic idle_inputs();
    gs = 0; gp = 0; ss = 0; sp = 0; done = 0; ena = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstb = 0;
    tick();
    rstb = 1;
  endtask

  initial begin
    //                 rstb ena gs gp ss sp dn     es ea by df af tf   rc
    tbl[0]  = {7'b0_1_0_0_0_0_0, 6'b0_0_0_0_0_0, 16'd0}; // reset
    tbl[1]  = {7'b1_1_0_0_0_0_0, 6'b0_0_0_0_0_0, 16'd0}; // idle
    tbl[2]  = {7'b1_1_1_0_0_0_0, 6'b1_0_1_0_0_0, 16'd0}; // gpio start -> LAUNCH
    tbl[3]  = {7'b1_1_0_0_0_0_0, 6'b0_0_1_0_0_0, 16'd0}; // RUN, count 0
    tbl[4]  = {7'b1_1_0_0_0_0_0, 6'b0_0_1_0_0_0, 16'd1};
    tbl[5]  = {7'b1_1_1_0_0_0_0, 6'b0_0_1_0_0_0, 16'd2}; // start in RUN ignored
    tbl[6]  = {7'b1_1_0_0_0_0_1, 6'b0_0_0_1_0_0, 16'd2}; // done -> IDLE
    tbl[7]  = {7'b1_1_0_0_0_0_1, 6'b0_0_0_1_0_0, 16'd2}; // done in IDLE ignored
    tbl[8]  = {7'b1_1_0_1_1_0_0, 6'b0_0_0_1_0_0, 16'd2}; // start+stop stays IDLE
    tbl[9]  = {7'b1_1_0_0_1_0_0, 6'b1_0_1_0_0_0, 16'd0}; // spi start clears flags
    tbl[10] = {7'b1_1_0_0_0_1_0, 6'b0_0_1_0_0_0, 16'd0}; // stop in LAUNCH ignored
    tbl[11] = {7'b1_1_0_0_0_0_0, 6'b0_0_1_0_0_0, 16'd1};
    tbl[12] = {7'b1_1_0_0_0_1_0, 6'b0_1_1_0_1_0, 16'd1}; // spi stop -> ABORT
    tbl[13] = {7'b1_1_1_0_0_0_0, 6'b0_0_0_0_1_0, 16'd1}; // start in ABORT ignored
    tbl[14] = {7'b1_0_1_0_0_0_0, 6'b0_0_0_0_1_0, 16'd1}; // start lost while ena=0
    tbl[15] = {7'b1_1_1_0_0_0_0, 6'b1_0_1_0_0_0, 16'd0}; // LAUNCH
    tbl[16] = {7'b1_0_0_0_0_0_0, 6'b0_0_1_0_0_0, 16'd0}; // ena=0 kills eng_start
    tbl[17] = {7'b1_1_0_0_0_0_0, 6'b0_0_1_0_0_0, 16'd0}; // RUN
    tbl[18] = {7'b1_1_0_1_0_0_1, 6'b0_0_0_1_0_0, 16'd0}; // done beats stop
    tbl[19] = {7'b0_0_0_0_0_0_0, 6'b0_0_0_0_0_0, 16'd0}; // reset ignores ena

    idle_inputs();
    rstb = 0;

    for (int i = 0; i < 20; i++) begin
      rstb = tbl[i].rstb; ena = tbl[i].ena;
      gs = tbl[i].gs; gp = tbl[i].gp; ss = tbl[i].ss; sp = tbl[i].sp; done = tbl[i].done;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'({tbl[i].flags, tbl[i].rc}));
    end

    // Done after ten cycles of RUN
    do_reset();
    es_cnt = 0;
    gs = 1; tick(); gs = 0;
    check("done_start_pulse", 32'(es), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    done = 1; tick(); done = 0;
    check("done_flag", 32'(df), 32'd1);
    check("done_rc", 32'(rc), 32'd9);
    check("done_busy", 32'(busy), 32'd0);
    check("done_start_count", 32'(es_cnt), 32'd1);

    // Stop at RUN cycle 5
    do_reset();
    ea_cnt = 0;
    ss = 1; tick(); ss = 0;
    for (int i = 0; i < 6; i++) tick();
    check("stop_rc_before", 32'(rc), 32'd5);
    gp = 1; tick(); gp = 0;
    check("stop_abort_pulse", 32'(ea), 32'd1);
    check("stop_flags", 32'({df, af, tf}), 32'b010);
    check("stop_rc", 32'(rc), 32'd5);
    tick();
    check("stop_abort_end", 32'({ea, busy}), 32'd0);
    check("stop_abort_count", 32'(ea_cnt), 32'd1);

    // Timeout on the TIMEOUT=8 instance
    do_reset();
    to_ea_cnt = 0;
    gs = 1; tick(); gs = 0;
    begin
      int  n;
      bit  seen;
      n = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        tick();
        n++;
        if (to_ea) seen = 1;
      end
      check("to_abort_seen", 32'(seen), 32'd1);
      check("to_abort_cycle", 32'(n), 32'd9);
    end
    check("to_rc", 32'(to_rc), 32'd7);
    check("to_flags", 32'({to_df, to_af, to_tf}), 32'b001);
    tick();
    check("to_abort_end", 32'({to_ea, to_busy}), 32'd0);
    check("to_abort_count", 32'(to_ea_cnt), 32'd1);

    // Clock-enable freeze mid-RUN, then reset mid-RUN
    do_reset();
    gs = 1; tick(); gs = 0;
    for (int i = 0; i < 4; i++) tick();
    check("ena_rc_before", 32'(rc), 32'd3);
    es_cnt = 0; ea_cnt = 0;
    ena = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ena_frozen%0d", i), 32'({busy, rc}), 32'h1_0003);
    end
    check("ena_no_pulses", 32'(es_cnt + ea_cnt), 32'd0);
    ena = 1; tick();
    check("ena_resume_rc", 32'(rc), 32'd4);
    rstb = 0; tick(); rstb = 1;
    check("rst_outputs", 32'(outs()), 32'd0);
    check("rst_no_abort", 32'(ea_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_cmd_ctrl.md
RSA_CMD_CTRL -- requirements
Module: rsa_cmd_ctrl

Interface
Parameters:
REQ-001 SHALL provide parameter CNT_W, default 16, width of the run-cycle counter.
REQ-002 SHALL provide parameter TIMEOUT, default 16'hFFFF, maximum RUN cycles before forced abort; legal range 2..2^CNT_W-1.

Ports:
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rstb  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port ena  input  1  clock enable; 0 freezes all state.
REQ-006 SHALL have port gpio_start_cmd  input  1  one-cycle start pulse from GPIO edge detector.
REQ-007 SHALL have port gpio_stop_cmd  input  1  one-cycle stop pulse from GPIO edge detector.
REQ-008 SHALL have port spi_start_cmd  input  1  one-cycle start pulse from SPI register block.
REQ-009 SHALL have port spi_stop_cmd  input  1  one-cycle stop pulse from SPI register block.
REQ-010 SHALL have port eng_done  input  1  RSA engine completion, level or pulse, sampled in RUN only.
REQ-011 SHALL have port eng_start  output  1  one-cycle launch pulse to RSA engine.
REQ-012 SHALL have port eng_abort  output  1  one-cycle abort pulse to RSA engine.
REQ-013 SHALL have port busy  output  1  high in LAUNCH, RUN, ABORT.
REQ-014 SHALL have port done_flag  output  1  sticky: last run completed normally.
REQ-015 SHALL have port abort_flag  output  1  sticky: last run stopped by stop command.
REQ-016 SHALL have port timeout_flag  output  1  sticky: last run hit TIMEOUT.
REQ-017 SHALL have port run_cycles  output  CNT_W  cycles spent in RUN by the last or current run.

Function
REQ-018 SHALL combine sources: start = gpio_start_cmd | spi_start_cmd; stop = gpio_stop_cmd | spi_stop_cmd.
REQ-019 SHALL implement states IDLE, LAUNCH, RUN, ABORT; all outputs registered.
REQ-020 IDLE: start & !stop -> LAUNCH, clearing done/abort/timeout flags and run_cycles in the same edge; start & stop together -> stay IDLE, flags unchanged.
REQ-021 LAUNCH: eng_start=1 for exactly this one cycle; unconditionally -> RUN next cycle.
REQ-022 RUN: run_cycles increments by 1 each enabled cycle, starting from 0 in the first RUN cycle.
REQ-023 RUN exit priority: eng_done -> IDLE, set done_flag; else stop -> ABORT, set abort_flag; else run_cycles == TIMEOUT-1 -> ABORT, set timeout_flag.
REQ-024 ABORT: eng_abort=1 for exactly this one cycle; -> IDLE next cycle.
REQ-025 start in LAUNCH, RUN or ABORT SHALL be ignored, with no restart and no flag change; stop in LAUNCH SHALL be ignored.
REQ-026 run_cycles SHALL hold its value in IDLE and never wrap; it is bounded by TIMEOUT-1.
REQ-027 Exactly one of done/abort/timeout flags SHALL be set after any completed run.
REQ-028 ena=0 SHALL hold state, flags and counter; eng_start/eng_abort forced 0; a pulse arriving while ena=0 is lost.
REQ-029 eng_done while not in RUN SHALL be ignored.

Reset
REQ-030 rstb=0 at a clk edge SHALL force IDLE, with all outputs 0 and run_cycles 0, regardless of ena.
REQ-031 Reset mid-run SHALL NOT emit eng_abort; the engine is reset by the same rstb.

Structure
REQ-032 State encoding, CNT_W and TIMEOUT defaults SHALL live in shared package rsa_ctrl_pkg.
REQ-033 The saturating-free run counter with clear/enable SHALL be sub-module rsa_cycle_counter; the FSM stays in rsa_cmd_ctrl.

Verification
REQ-034 gpio_start_cmd pulse, eng_done 10 cycles after eng_start -> eng_start one pulse 1 cycle after start, done_flag=1, run_cycles=9, busy low.
REQ-035 spi_start_cmd then gpio_stop_cmd at RUN cycle 5 -> eng_abort pulse next cycle, abort_flag=1, run_cycles=5, done_flag=0.
REQ-036 TIMEOUT=8, no eng_done -> ABORT after run_cycles=7, timeout_flag=1, eng_abort single pulse.
REQ-037 eng_done and stop in the same RUN cycle -> done_flag=1, no eng_abort; start+stop same cycle in IDLE -> no eng_start.
REQ-038 ena=0 for 4 cycles mid-RUN -> run_cycles frozen, no outputs pulsing; rstb=0 mid-RUN -> IDLE and all outputs 0 next edge, no eng_abort.
